// File: rtl/stream_demux_1_2_pkg.sv
// Shared types and constants for the packet-aware 1:2 stream demultiplexer.
package stream_demux_1_2_pkg;

  // Packet-routing FSM: IDLE waits for a first beat, LOCK follows a packet to its end.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Destination select values carried on in_sel / lock_sel.
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/stream_demux_1_2_if.sv
// Bundles the input stream and both output streams of the demultiplexer.
// master = the environment (source + sinks), slave = the demultiplexer itself.
interface stream_demux_1_2_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_sel;

  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_last;

  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_last;

  modport master (
    output in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last,
           out1_valid, out1_data, out1_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last,
           out1_valid, out1_data, out1_last
  );

endinterface

// File: rtl/stream_demux_1_2_fifo.sv
// Small synchronous FIFO used as the per-output buffer of the demultiplexer.
// Full/empty derive from an occupancy counter one bit wider than the pointers.
module stream_demux_1_2_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full      = (r_count == DEPTH_CNT);
  assign empty     = (r_count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy update on push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset on purpose: the head is visible on the output
      // bus even while empty, and it must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_1_2.sv
// Registered, packet-aware 1:2 stream demultiplexer. The first beat of a packet
// picks the destination; the FSM locks it until the last beat. Each output has
// its own FIFO so a stalled sink only blocks traffic bound for it.
module stream_demux_1_2
  import stream_demux_1_2_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_demux_1_2_if.slave    bus,
  output logic [CNT_W-1:0]     pkt_cnt0,
  output logic [CNT_W-1:0]     pkt_cnt1
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_lock_sel;
  logic             w_lock_sel_nxt;
  logic             w_target;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_push0;
  logic             w_push1;
  logic             w_full0;
  logic             w_full1;
  logic             w_empty0;
  logic             w_empty1;
  logic [DATA_W:0]  w_dout0;
  logic [DATA_W:0]  w_dout1;
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;

  // Target selection, input ready and next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_lock_sel_nxt = r_lock_sel;
    w_target       = bus.in_sel;

    if (r_state == ST_LOCK) begin
      w_target = r_lock_sel;
    end

    // Ready depends only on the target FIFO's fill level, never on in_valid.
    w_in_ready = (w_target == SEL_OUT1) ? ~w_full1 : ~w_full0;
    w_accept   = bus.in_valid & w_in_ready;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && !bus.in_last) begin
          w_state_nxt    = ST_LOCK;
          w_lock_sel_nxt = bus.in_sel;
        end
      end
      ST_LOCK: begin
        if (w_accept && bus.in_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and locked destination registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= SEL_OUT0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_sel <= w_lock_sel_nxt;
    end
  end

  // Per-output packet counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else if (w_accept && bus.in_last) begin
      if (w_target == SEL_OUT1) begin
        r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
      end else begin
        r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
      end
    end
  end

  assign w_push0 = w_accept & (w_target == SEL_OUT0);
  assign w_push1 = w_accept & (w_target == SEL_OUT1);

  stream_demux_1_2_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push0),
    .din   ({bus.in_last, bus.in_data}),
    .full  (w_full0),
    .pop   (bus.out0_valid & bus.out0_ready),
    .dout  (w_dout0),
    .empty (w_empty0)
  );

  stream_demux_1_2_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push1),
    .din   ({bus.in_last, bus.in_data}),
    .full  (w_full1),
    .pop   (bus.out1_valid & bus.out1_ready),
    .dout  (w_dout1),
    .empty (w_empty1)
  );

  assign bus.in_ready                   = w_in_ready;
  assign bus.out0_valid                 = ~w_empty0;
  assign {bus.out0_last, bus.out0_data} = w_dout0;
  assign bus.out1_valid                 = ~w_empty1;
  assign {bus.out1_last, bus.out1_data} = w_dout1;
  assign pkt_cnt0                       = r_pkt_cnt0;
  assign pkt_cnt1                       = r_pkt_cnt1;

endmodule
